// File: rtl/fir_bus_sequencer.sv
// Master for the FIR op/data input bus: arbitrates config vs samples,
// serialises coefficient/preset writes and tags FIR outputs with validity.
module fir_bus_sequencer #(
  parameter bit CHECK_EN   = 1'b1,
  parameter int FILL_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_req,
  input  logic       cfg_kind,
  input  logic [5:0] cfg_h0,
  input  logic [5:0] cfg_h1,
  input  logic [5:0] cfg_h23,
  input  logic [1:0] cfg_mode,
  output logic       cfg_ack,
  output logic       cfg_err,
  input  logic       cfg_err_clr,
  input  logic       smp_valid,
  input  logic [5:0] smp_data,
  output logic       smp_ready,
  output logic [7:0] fir_bus,
  input  logic       fir_upd_flag,
  output logic       busy,
  output logic       y_strobe,
  output logic       y_valid
);

  typedef enum logic [2:0] {
    IDLE, C_H0, C_H1, C_H23, C_MODE, CHECK, REJ
  } state_t;

  localparam logic [2:0] FD = FILL_DEPTH[2:0];

  state_t     state;
  logic       last_smp;
  logic [5:0] h1;
  logic [5:0] h23;
  logic [5:0] shadow_h0;
  logic [2:0] fill;
  logic       p1s, p1v;
  logic       p2s, p2v;

  logic       idle;
  logic       cfg_grant;
  logic       hs;
  logic [2:0] fill_inc;
  logic       hs_valid;
  logic [7:0] idle_word;
  logic [5:0] preset_h0;
  logic       err_set;

  always_comb begin
    idle      = (state == IDLE);
    smp_ready = idle && !(cfg_req && last_smp);
    cfg_grant = idle && cfg_req && (last_smp || !smp_valid);
    hs        = smp_ready && smp_valid;
    fill_inc  = (fill < FD) ? fill + 3'd1 : fill;
    hs_valid  = (fill_inc >= FD);
    idle_word = {2'b01, shadow_h0};
    preset_h0 = (cfg_mode == 2'b10) ? 6'd4 : 6'd1;
    err_set   = (state == REJ) ||
                ((state == CHECK) && CHECK_EN && !fir_upd_flag);
    busy      = !idle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_smp  <= 1'b1;
      h1        <= '0;
      h23       <= '0;
      shadow_h0 <= 6'd1;
      fill      <= '0;
      fir_bus   <= 8'h41;
      cfg_ack   <= 1'b0;
    end else begin
      cfg_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_grant) begin
            last_smp <= 1'b0;
            fill     <= '0;
            h1       <= cfg_h1;
            h23      <= cfg_h23;
            if (cfg_kind) begin
              state     <= C_MODE;
              shadow_h0 <= preset_h0;
              fir_bus   <= {2'b11, cfg_mode, 4'b1000};
            end else if (cfg_h23[3]) begin
              // FIR would decode this h23 word as a preset load
              state   <= REJ;
              fir_bus <= idle_word;
              cfg_ack <= 1'b1;
            end else begin
              state     <= C_H0;
              shadow_h0 <= cfg_h0;
              fir_bus   <= {2'b01, cfg_h0};
            end
          end else if (hs) begin
            last_smp <= 1'b1;
            fill     <= fill_inc;
            fir_bus  <= {2'b00, smp_data};
          end else begin
            fir_bus <= idle_word;
          end
        end
        C_H0: begin
          state   <= C_H1;
          fir_bus <= {2'b10, h1};
        end
        C_H1: begin
          state   <= C_H23;
          fir_bus <= {2'b11, h23};
        end
        C_H23, C_MODE: begin
          state   <= CHECK;
          fir_bus <= idle_word;
          cfg_ack <= 1'b1;
        end
        CHECK, REJ: begin
          state   <= IDLE;
          fir_bus <= idle_word;
        end
        default: begin
          state   <= IDLE;
          fir_bus <= idle_word;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else if (err_set) begin
      cfg_err <= 1'b1;
    end else if (cfg_err_clr) begin
      cfg_err <= 1'b0;
    end
  end

  // Strobe lands when FIR uo_out reflects the sample, three cycles on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1s      <= 1'b0;
      p1v      <= 1'b0;
      p2s      <= 1'b0;
      p2v      <= 1'b0;
      y_strobe <= 1'b0;
      y_valid  <= 1'b0;
    end else begin
      p1s      <= hs;
      p1v      <= hs && hs_valid;
      p2s      <= p1s;
      p2v      <= p1v && !cfg_grant;
      y_strobe <= p2s;
      y_valid  <= p2s && p2v && !cfg_grant;
    end
  end

endmodule

// File: tb/tb_fir_bus_sequencer.sv
// Randomised bench for fir_bus_sequencer against a transaction-level
// model: each accepted config expands into a list of expected bus beats.
module tb_fir_bus_sequencer;

  localparam int FILL_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_req = 1'b0;
  logic       cfg_kind = 1'b0;
  logic [5:0] cfg_h0 = '0;
  logic [5:0] cfg_h1 = '0;
  logic [5:0] cfg_h23 = '0;
  logic [1:0] cfg_mode = '0;
  logic       cfg_ack;
  logic       cfg_err;
  logic       cfg_err_clr = 1'b0;
  logic       smp_valid = 1'b0;
  logic [5:0] smp_data = '0;
  logic       smp_ready;
  logic [7:0] fir_bus;
  logic       fir_upd_flag = 1'b1;
  logic       busy;
  logic       y_strobe;
  logic       y_valid;

  always #5 clk = ~clk;

  fir_bus_sequencer #(.CHECK_EN(1'b1), .FILL_DEPTH(FILL_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_req(cfg_req), .cfg_kind(cfg_kind),
    .cfg_h0(cfg_h0), .cfg_h1(cfg_h1), .cfg_h23(cfg_h23),
    .cfg_mode(cfg_mode), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .cfg_err_clr(cfg_err_clr),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
    .fir_bus(fir_bus), .fir_upd_flag(fir_upd_flag), .busy(busy),
    .y_strobe(y_strobe), .y_valid(y_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] w;
    bit         ack;
    bit         chk;
    bit         rej;
  } beat_t;

  typedef struct {
    int t;
    bit v;
  } strb_t;

  beat_t      script[$];
  strb_t      sq[$];
  logic [7:0] m_bus = 8'h41;
  bit         m_ack = 1'b0;
  bit         m_err = 1'b0;
  bit         m_last_smp = 1'b1;
  logic [5:0] m_sh0 = 6'd1;
  int         m_cnt = 0;
  int         cyc = 0;

  bit  m_idle, m_grant, m_hs, m_eset;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      script.delete();
      sq.delete();
      m_bus = 8'h41;
      m_ack = 1'b0;
      m_err = 1'b0;
      m_last_smp = 1'b1;
      m_sh0 = 6'd1;
      m_cnt = 0;
      cyc = 0;
    end else begin
      m_idle  = (script.size() == 0);
      m_grant = m_idle && cfg_req && (m_last_smp || !smp_valid);
      m_hs    = m_idle && smp_valid && !(cfg_req && m_last_smp);
      m_eset  = 1'b0;
      if (!m_idle) begin
        m_eset = script[0].rej || (script[0].chk && !fir_upd_flag);
        void'(script.pop_front());
      end
      if (m_eset) m_err = 1'b1;
      else if (cfg_err_clr) m_err = 1'b0;
      if (m_hs) begin
        m_cnt++;
        sq.push_back('{cyc + 3, m_cnt >= FILL_DEPTH});
        m_last_smp = 1'b1;
      end
      if (m_grant) begin
        m_last_smp = 1'b0;
        m_cnt = 0;
        foreach (sq[i]) sq[i].v = 1'b0;
        if (cfg_kind) begin
          m_sh0 = (cfg_mode == 2'b10) ? 6'd4 : 6'd1;
          script.push_back('{{2'b11, cfg_mode, 4'b1000}, 0, 0, 0});
          script.push_back('{{2'b01, m_sh0}, 1, 1, 0});
        end else if (cfg_h23[3]) begin
          script.push_back('{{2'b01, m_sh0}, 1, 0, 1});
        end else begin
          m_sh0 = cfg_h0;
          script.push_back('{{2'b01, cfg_h0}, 0, 0, 0});
          script.push_back('{{2'b10, cfg_h1}, 0, 0, 0});
          script.push_back('{{2'b11, cfg_h23}, 0, 0, 0});
          script.push_back('{{2'b01, cfg_h0}, 1, 1, 0});
        end
      end
      cyc++;
      if (script.size() != 0) begin
        m_bus = script[0].w;
        m_ack = script[0].ack;
      end else begin
        m_bus = m_hs ? {2'b00, smp_data} : {2'b01, m_sh0};
        m_ack = 1'b0;
      end
    end
  end

  bit e_s, e_v;

  always @(negedge clk) begin
    e_s = (sq.size() != 0) && (sq[0].t == cyc);
    e_v = e_s && sq[0].v;
    if (e_s) void'(sq.pop_front());
    check("fir_bus", fir_bus, m_bus);
    check("cfg_ack", cfg_ack, m_ack);
    check("cfg_err", cfg_err, m_err);
    check("smp_ready", smp_ready,
          (script.size() == 0) && !(cfg_req && m_last_smp));
    check("busy", busy, script.size() != 0);
    check("y_strobe", y_strobe, e_s);
    check("y_valid", y_valid, e_v);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_cfg(input bit kind, input logic [5:0] a,
                        input logic [5:0] b, input logic [5:0] c,
                        input logic [1:0] m);
    bit got;
    got = 1'b0;
    cfg_kind = kind;
    cfg_h0 = a;
    cfg_h1 = b;
    cfg_h23 = c;
    cfg_mode = m;
    cfg_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cfg_ack) begin
        got = 1'b1;
        break;
      end
    end
    cfg_req = 1'b0;
    check("ack_seen", got, 1'b1);
  endtask

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("reset_bus", fir_bus, 8'h41);
    check("reset_ready", smp_ready, 1'b1);

    do_cfg(1'b1, 6'd0, 6'd0, 6'd0, 2'b01);
    tick();
    for (int i = 0; i < 5; i++) begin
      smp_valid = 1'b1;
      smp_data = 6'(5 + i);
      tick();
    end
    smp_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    do_cfg(1'b1, 6'd0, 6'd0, 6'd0, 2'b10);
    check("lp_idle_word", fir_bus, 8'h44);
    tick();
    check("lp_err", cfg_err, 1'b0);
    tick();

    do_cfg(1'b0, 6'd3, 6'd5, 6'b010_010, 2'b00);
    check("custom_idle_word", fir_bus, 8'h43);
    tick();
    for (int i = 0; i < 4; i++) begin
      smp_valid = 1'b1;
      smp_data = 6'($urandom);
      tick();
    end
    smp_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    do_cfg(1'b0, 6'd9, 6'd9, 6'b001_000, 2'b00);
    check("rej_bus", fir_bus, 8'h43);
    tick();
    check("rej_err_set", cfg_err, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    check("rej_err_hold", cfg_err, 1'b1);
    cfg_err_clr = 1'b1;
    tick();
    cfg_err_clr = 1'b0;
    check("rej_err_clr", cfg_err, 1'b0);

    fir_upd_flag = 1'b0;
    cfg_kind = 1'b0;
    cfg_h0 = 6'd2;
    cfg_h1 = 6'd3;
    cfg_h23 = 6'b010_001;
    cfg_req = 1'b1;
    smp_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      smp_data = 6'($urandom);
      tick();
    end
    for (int i = 0; i < 10 && !cfg_ack; i++) tick();
    cfg_req = 1'b0;
    smp_valid = 1'b0;
    tick();
    check("flag_err", cfg_err, 1'b1);
    fir_upd_flag = 1'b1;
    cfg_err_clr = 1'b1;
    tick();
    cfg_err_clr = 1'b0;

    cfg_h0 = 6'd7;
    cfg_h1 = 6'd8;
    cfg_h23 = 6'd1;
    cfg_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy && fir_bus[7:6] == 2'b10) break;
    end
    check("mid_h1", fir_bus, {2'b10, 6'd8});
    rst_n = 1'b0;
    #1;
    check("abort_bus", fir_bus, 8'h41);
    check("abort_ack", cfg_ack, 1'b0);
    check("abort_busy", busy, 1'b0);
    cfg_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    for (int i = 0; i < 600; i++) begin
      tick();
      if (cfg_req && cfg_ack) begin
        cfg_req = 1'b0;
      end else if (!cfg_req && $urandom_range(0, 7) == 0) begin
        cfg_kind = 1'($urandom);
        cfg_h0 = 6'($urandom);
        cfg_h1 = 6'($urandom);
        cfg_h23 = 6'($urandom);
        if ($urandom_range(0, 3) != 0) cfg_h23[3] = 1'b0;
        cfg_mode = 2'($urandom);
        cfg_req = 1'b1;
      end
      smp_valid = ($urandom_range(0, 2) != 0);
      smp_data = 6'($urandom);
      fir_upd_flag = ($urandom_range(0, 5) != 0);
      cfg_err_clr = ($urandom_range(0, 9) == 0);
    end
    smp_valid = 1'b0;
    cfg_err_clr = 1'b0;
    for (int i = 0; i < 20 && cfg_req; i++) begin
      tick();
      if (cfg_ack) cfg_req = 1'b0;
    end
    check("drain_req", cfg_req, 1'b0);
    for (int i = 0; i < 10; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_bus_sequencer.md
Name: fir_bus_sequencer

Overview:
- Master for the FIR filter's 8-bit op/data input bus (op[7:6], payload[5:0]).
- Arbitrates between a configuration requester and a sample stream, and serialises coefficient and preset-mode writes into bus beats.
- Because op 00 always shifts the FIR delay line, drives a non-destructive idle word whenever no sample is issued.
- Checks the FIR coefficient-update flag after each config and flags FIR outputs computed under stale coefficients or a partially filled delay line.

Parameters:
- CHECK_EN, 1, 1 = verify fir_upd_flag after each configuration; 0 = skip the check (cfg_err is then set only by rejects).
- FILL_DEPTH, 4, number of samples after reset/config before y_valid may assert; counter is 3 bits.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_req  in  1  level; held with fields stable until cfg_ack.
- cfg_kind  in  1  0 = custom coefficients, 1 = preset mode.
- cfg_h0  in  6  custom h0.
- cfg_h1  in  6  custom h1.
- cfg_h23  in  6  custom h2/h3 payload; [5:3] = h2 field, [2:0] = h3.
- cfg_mode  in  2  preset: 00 bypass, 01 avg, 10 lowpass, 11 highpass.
- cfg_ack  out  1  one-cycle completion pulse.
- cfg_err  out  1  sticky error.
- cfg_err_clr  in  1  clears cfg_err.
- smp_valid  in  1  sample handshake valid.
- smp_data  in  6  sample value.
- smp_ready  out  1  sample handshake ready.
- fir_bus  out  8  registered; connects to FIR ui_in.
- fir_upd_flag  in  1  FIR coefficient-update flag (FIR uio_out[0]).
- busy  out  1  state != IDLE.
- y_strobe  out  1  FIR uo_out holds the result of an issued sample this cycle.
- y_valid  out  1  qualifies y_strobe.

Behaviour:
- Reset values:
  - fir_bus = 0x41, the idle word ({01, shadow_h0}) with shadow_h0 = 1.
  - state = IDLE; last_grant = SMP.
  - cfg_ack, cfg_err, y_strobe, y_valid = 0; fill = 0.
  - Reset mid-transaction aborts the transaction; no ack is issued.
- Idle word: {2'b01, shadow_h0}. It rewrites the FIR's current h0, leaving taps and coefficients unchanged. It is driven in every cycle that carries no sample or config beat.
- shadow_h0 update at config acceptance:
  - Custom: shadow_h0 <= cfg_h0.
  - Preset: shadow_h0 <= 1 for bypass, avg and highpass; 4 for lowpass.
- Arbitration, evaluated in IDLE only:
  - cfg_grant = cfg_req && (last_grant == SMP || !smp_valid).
  - smp_ready = IDLE && !(cfg_req && last_grant == SMP). It does not depend on smp_valid.
  - last_grant updates on every grant or handshake.
- Sample path:
  - Handshake in cycle n puts {00, smp_data} on fir_bus in cycle n+1.
  - y_strobe is high in cycle n+3, when FIR uo_out reflects that sample.
  - Back-to-back handshakes are allowed, one per cycle.
  - fill saturates at FILL_DEPTH and increments on each handshake.
  - The sample's valid bit = (fill after increment >= FILL_DEPTH). It travels with the strobe and appears on y_valid alongside y_strobe.
- Config acceptance (cfg_grant in IDLE):
  - Fields are latched at acceptance.
  - fill clears to 0.
  - Valid bits of strobes already in flight are cleared; those strobes still fire, with y_valid = 0.
- State machine:
  - IDLE -> C_H0 when custom and cfg_h23[3] == 0.
  - IDLE -> C_MODE when preset.
  - IDLE -> REJ when custom and cfg_h23[3] == 1. FIR would decode that word as a preset load.
  - C_H0: bus = {01, h0}; next state C_H1.
  - C_H1: bus = {10, h1}; next state C_H23.
  - C_H23: bus = {11, h23}; next state CHECK.
  - C_MODE: bus = {11, mode, 4'b1000}; next state CHECK.
  - CHECK: bus = idle word. cfg_ack = 1. If CHECK_EN && !fir_upd_flag, set cfg_err. Next state IDLE.
  - REJ: no beats issued. cfg_ack = 1; set cfg_err; next state IDLE.
- Bus registering: bus words are registered, so each state's word appears in the cycle that state is occupied. This puts the flag sampled in CHECK one cycle after the last beat.
- smp_ready = 0 in all non-IDLE states.
- cfg_err:
  - Set by CHECK failure or REJ.
  - cfg_err_clr clears it.
  - Set wins over a simultaneous clear.
- The requester must deassert cfg_req in the cycle after cfg_ack. A cfg_req still high in IDLE is treated as a new request.

Test Plan:
- Reset, no requests -> fir_bus = 0x41 constant; smp_ready = 1; y_strobe = 0.
- Samples 5, 6, 7, 8, 9 back-to-back from reset, avg mode -> y_strobe 3 cycles after each handshake. y_valid = 0 for the first three and 1 from the fourth (sample 8) onward.
- Preset lowpass (cfg_mode = 10) -> fir_bus 0xE8 for one cycle, then 0x44. cfg_ack in the next cycle; cfg_err = 0. FIR coefficients read back 4, 2, 1, 1.
- Custom h0 = 3, h1 = 5, h23 = 6'b010_010 -> bus 0x43, 0x85, 0xD2, then idle 0x43. cfg_ack pulses; the next 3 strobes have y_valid = 0.
- Custom with cfg_h23 = 6'b001_000 -> no beats; cfg_ack pulses 1 cycle after acceptance. cfg_err = 1 and holds until cfg_err_clr.
- cfg_req and smp_valid both held high -> grants alternate cfg, sample, cfg, … with cfg first after reset. Tie fir_upd_flag to 0 -> cfg_err sets at CHECK. Assert rst_n mid-C_H1 -> fir_bus = 0x41 with no ack.
